// File: rtl/ex_debounce.sv
// ---------------------------------------------------------------------------
// ex_debounce
// Debounces a bouncy asynchronous key/switch input. The raw input is brought
// into the sclk domain through a two-flop synchronizer. A four-state FSM then
// accepts a new level only after the synchronized sample has held it for
// DEB_CYCLES consecutive edges. Every aborted check is counted as a glitch.
//
// Parameters
//   DEB_CYCLES  consecutive equal samples needed to accept a level (2..65535)
//
// Ports
//   sclk        clock; all state updates on its rising edge
//   rst_n       synchronous active-low reset
//   key_raw     asynchronous raw key input
//   A           debounced level, straight from a flop
//   A_rise      one-cycle pulse in the cycle A goes 0->1
//   A_fall      one-cycle pulse in the cycle A goes 1->0
//   glitch_cnt  count of rejected transitions, saturating at 255
// ---------------------------------------------------------------------------
module ex_debounce #(
   parameter int unsigned DEB_CYCLES = 16
) (
   input  logic       sclk,
   input  logic       rst_n,
   input  logic       key_raw,
   output logic       A,
   output logic       A_rise,
   output logic       A_fall,
   output logic [7:0] glitch_cnt
);

   typedef enum logic [1:0] {
      ST_LO  = 2'd0,
      CHK_HI = 2'd1,
      ST_HI  = 2'd2,
      CHK_LO = 2'd3
   } state_e;

   localparam logic [15:0] CNT_LAST = 16'(DEB_CYCLES - 1);

   logic        sync1_q, sync2_q;
   logic        s;
   state_e      state_q, state_d;
   logic [15:0] cnt_q, cnt_d;
   logic        a_q, a_d;
   logic        rise_q, rise_d;
   logic        fall_q, fall_d;
   logic [7:0]  glitch_q, glitch_d;
   logic        reject;

   assign s = sync2_q;

   // Next-state logic and registered outputs.
   // NOTE: every signal written here gets a default first, so no path through
   // the case statement can leave a value unassigned and infer a latch.
   always_comb begin
      state_d = state_q;
      cnt_d   = 16'd0;
      a_d     = a_q;
      rise_d  = 1'b0;
      fall_d  = 1'b0;
      reject  = 1'b0;

      unique case (state_q)
         ST_LO: begin
            if (s) begin
               state_d = CHK_HI;
               cnt_d   = 16'd1;
            end
         end
         CHK_HI: begin
            if (!s) begin
               state_d = ST_LO;
               reject  = 1'b1;
            end else if (cnt_q == CNT_LAST) begin
               state_d = ST_HI;
               a_d     = 1'b1;
               rise_d  = 1'b1;
            end else begin
               cnt_d = cnt_q + 16'd1;
            end
         end
         ST_HI: begin
            if (!s) begin
               state_d = CHK_LO;
               cnt_d   = 16'd1;
            end
         end
         CHK_LO: begin
            if (s) begin
               state_d = ST_HI;
               reject  = 1'b1;
            end else if (cnt_q == CNT_LAST) begin
               state_d = ST_LO;
               a_d     = 1'b0;
               fall_d  = 1'b1;
            end else begin
               cnt_d = cnt_q + 16'd1;
            end
         end
         default: begin
            state_d = ST_LO;
         end
      endcase

      // Saturate instead of wrapping so a long bounce storm stays visible.
      glitch_d = (reject && glitch_q != 8'hFF) ? glitch_q + 8'd1 : glitch_q;
   end

   // NOTE: state uses non-blocking assignments so every flop samples the
   // pre-edge values of the others, independent of statement order.
   // Reset is synchronous: it only takes effect on a rising sclk edge, and it
   // silently abandons any check in progress (no pulse, no glitch count).
   always_ff @(posedge sclk) begin
      if (!rst_n) begin
         sync1_q  <= 1'b0;
         sync2_q  <= 1'b0;
         state_q  <= ST_LO;
         cnt_q    <= 16'd0;
         a_q      <= 1'b0;
         rise_q   <= 1'b0;
         fall_q   <= 1'b0;
         glitch_q <= 8'd0;
      end else begin
         sync1_q  <= key_raw;
         sync2_q  <= sync1_q;
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         a_q      <= a_d;
         rise_q   <= rise_d;
         fall_q   <= fall_d;
         glitch_q <= glitch_d;
      end
   end

   assign A          = a_q;
   assign A_rise     = rise_q;
   assign A_fall     = fall_q;
   assign glitch_cnt = glitch_q;

endmodule

// File: tb/tb_ex_debounce.sv
// ---------------------------------------------------------------------------
// tb_ex_debounce
// Self-checking bench for ex_debounce (DEB_CYCLES = 16, sclk period 20 ns).
// The driver applies inputs on the falling edge and advances a reference
// model that tracks the accepted level and the length of the current run of
// synchronized samples that disagree with it. The expected outputs for the
// following rising edge are queued; a monitor pops and compares them 1 ns
// after each rising edge. Directed checks cover latency and glitch totals.
// ---------------------------------------------------------------------------
module tb_ex_debounce;

   localparam int DEB = 16;

   typedef struct packed {
      logic       a;
      logic       rise;
      logic       fall;
      logic [7:0] glitch;
   } obs_t;

   logic       sclk = 1'b0;
   logic       rst_n = 1'b0;
   logic       key_raw = 1'b0;
   logic       A, A_rise, A_fall;
   logic [7:0] glitch_cnt;

   int errors = 0;
   int checks = 0;

   obs_t exp_q[$];

   // Reference model state.
   logic m_s1 = 1'b0, m_s2 = 1'b0;
   logic m_a = 1'b0;
   int   m_run = 0;
   int   m_glitch = 0;
   logic m_rise = 1'b0, m_fall = 1'b0;

   ex_debounce #(.DEB_CYCLES(DEB)) dut (
      .sclk       (sclk),
      .rst_n      (rst_n),
      .key_raw    (key_raw),
      .A          (A),
      .A_rise     (A_rise),
      .A_fall     (A_fall),
      .glitch_cnt (glitch_cnt)
   );

   always #10 sclk = ~sclk;

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
      checks++;
      if (got !== want) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, got, want, $time);
      end
   endtask

   // One rising edge of the reference: a new level is accepted once the
   // synchronized sample has disagreed with the current level on DEB
   // consecutive edges; falling back to the old level mid-run is a glitch.
   task automatic model_edge(input logic rstn, input logic raw);
      logic s;
      if (!rstn) begin
         m_s1 = 0; m_s2 = 0; m_a = 0; m_run = 0; m_glitch = 0;
         m_rise = 0; m_fall = 0;
      end else begin
         s      = m_s2;
         m_s2   = m_s1;
         m_s1   = raw;
         m_rise = 0;
         m_fall = 0;
         if (s != m_a) begin
            m_run++;
            if (m_run == DEB) begin
               m_a    = s;
               m_rise = s;
               m_fall = ~s;
               m_run  = 0;
            end
         end else begin
            if (m_run > 0 && m_glitch < 255) m_glitch++;
            m_run = 0;
         end
      end
   endtask

   task automatic step(input logic raw, input logic rstn);
      obs_t e;
      @(negedge sclk);
      key_raw = raw;
      rst_n   = rstn;
      model_edge(rstn, raw);
      e.a      = m_a;
      e.rise   = m_rise;
      e.fall   = m_fall;
      e.glitch = 8'(m_glitch);
      exp_q.push_back(e);
   endtask

   task automatic hold(input logic raw, input int n);
      for (int i = 0; i < n; i++) step(raw, 1'b1);
   endtask

   // Drive raw for up to n edges and report on which edge (1-based) A first
   // showed the level `lvl`; 0 if it never did.
   task automatic hold_until(input logic raw, input int n, input logic lvl, output int first);
      first = 0;
      for (int i = 1; i <= n; i++) begin
         step(raw, 1'b1);
         @(posedge sclk);
         #1;
         if (first == 0 && A === lvl) first = i;
      end
   endtask

   // Monitor: every rising edge presents a new output sample.
   always @(posedge sclk) begin
      obs_t g, e;
      #1;
      if (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         g = {A, A_rise, A_fall, glitch_cnt};
         check("outputs{A,rise,fall,glitch}", 32'(g), 32'(e));
         if (A_rise === 1'b1 && A_fall === 1'b1) check("rise_and_fall_both", 32'd1, 32'd0);
      end
   end

   initial begin
      int lat;
      int dur;
      int rises;

      // Reset for 100 ns with key low.
      for (int i = 0; i < 5; i++) step(1'b0, 1'b0);
      hold(1'b0, 5);

      // Four short bounces, A stays low.
      for (int r = 0; r < 4; r++) begin
         hold(1'b1, 5);
         hold(1'b0, 5);
      end
      hold(1'b0, 10);
      @(posedge sclk); #1;
      check("bounce_glitch_cnt", 32'(glitch_cnt), 32'd4);
      check("bounce_A", 32'(A), 32'd0);

      // Clean rising step: A rises on the 18th edge counting the first
      // sampling edge as edge 1.
      rises = 0;
      hold_until(1'b1, 300, 1'b1, lat);
      check("rise_latency", 32'(lat), 32'(DEB + 2));
      check("step_glitch_cnt", 32'(glitch_cnt), 32'd4);

      // Low for exactly DEB-1 edges is rejected.
      hold(1'b0, DEB - 1);
      hold(1'b1, 10);
      @(posedge sclk); #1;
      check("near_miss_A", 32'(A), 32'd1);
      check("near_miss_glitch_cnt", 32'(glitch_cnt), 32'd5);

      // Long low falls.
      hold_until(1'b0, 40, 1'b0, lat);
      check("fall_latency", 32'(lat), 32'(DEB + 2));

      // 300 bounce bursts saturate the glitch counter.
      for (int r = 0; r < 300; r++) begin
         hold(1'b1, 3);
         hold(1'b0, 3);
      end
      hold(1'b0, 4);
      @(posedge sclk); #1;
      check("saturated_glitch_cnt", 32'(glitch_cnt), 32'd255);
      check("saturated_A", 32'(A), 32'd0);

      // Reset during a rising check (cnt = 10), then key stays high.
      hold(1'b1, 12);
      step(1'b1, 1'b0);
      @(posedge sclk); #1;
      check("mid_reset_glitch_cnt", 32'(glitch_cnt), 32'd0);
      check("mid_reset_A", 32'(A), 32'd0);
      hold_until(1'b1, 40, 1'b1, lat);
      check("post_reset_rise_latency", 32'(lat), 32'(DEB + 2));

      // Randomized holds of varied length with rare resets.
      for (int r = 0; r < 150; r++) begin
         dur = int'($urandom_range(1, 40));
         if ($urandom_range(0, 49) == 0) step($urandom_range(0, 1) == 1, 1'b0);
         hold($urandom_range(0, 1) == 1, dur);
      end

      @(posedge sclk); #2;
      @(posedge sclk); #2;
      check("queue_drained", 32'(exp_q.size()), 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/ex_debounce.md
EX_DEBOUNCE -- requirements
Module: ex_debounce

Interface
REQ-001 Parameter DEB_CYCLES, default 16, SHALL be the number of consecutive equal synchronized samples required to accept a new level; legal range 2..65535.
REQ-002 Port sclk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-003 Port rst_n  input  1  SHALL be the reset: synchronous, active-low.
REQ-004 Port key_raw  input  1  SHALL be the asynchronous, bouncy raw input (button/switch).
REQ-005 Port A  output  1  SHALL be the debounced level, registered, which feeds the downstream FSM input A directly.
REQ-006 Port A_rise  output  1  SHALL be a one-cycle pulse coincident with the cycle A goes 0->1.
REQ-007 Port A_fall  output  1  SHALL be a one-cycle pulse coincident with the cycle A goes 1->0.
REQ-008 Port glitch_cnt  output  8  SHALL count rejected transitions (bounces), saturating at 255.

Function
REQ-009 key_raw SHALL pass through a 2-flop synchronizer (sync1, sync2); only sync2 (s) is used by logic below.
REQ-010 FSM SHALL have exactly four states: ST_LO, CHK_HI, ST_HI, CHK_LO.
REQ-011 ST_LO: s=1 -> CHK_HI with cnt<=1; else stay, cnt<=0.
REQ-012 CHK_HI: s=0 -> ST_LO, cnt<=0, glitch_cnt increments; s=1 and cnt==DEB_CYCLES-1 -> ST_HI, A<=1, A_rise<=1, cnt<=0; otherwise cnt<=cnt+1.
REQ-013 ST_HI: s=0 -> CHK_LO with cnt<=1; else stay, cnt<=0.
REQ-014 CHK_LO: s=1 -> ST_HI, cnt<=0, glitch_cnt increments; s=0 and cnt==DEB_CYCLES-1 -> ST_LO, A<=0, A_fall<=1, cnt<=0; otherwise cnt<=cnt+1.
REQ-015 A SHALL change only on the edge on which s has held the new value for DEB_CYCLES consecutive edges; a clean raw step therefore reaches A DEB_CYCLES+2 edges after the first edge that samples the new raw value.
REQ-016 A_rise/A_fall SHALL be 0 in every cycle other than the one following an accepting transition; they SHALL never both be 1.
REQ-017 cnt SHALL be 16 bits and SHALL never exceed DEB_CYCLES-1; no wrap-around possible.
REQ-018 glitch_cnt SHALL hold at 255 once reached; a rejection at 255 SHALL not wrap to 0.
REQ-019 A sample that returns to the old level on the very accepting edge (cnt==DEB_CYCLES-1) SHALL count as rejection; acceptance requires s equal to new level on that edge.
REQ-020 A SHALL be glitch-free (driven directly from a flop, no combinational path from key_raw).

Reset
REQ-021 While rst_n=0 at a rising sclk edge: sync1, sync2, A, A_rise, A_fall <= 0; cnt <= 0; glitch_cnt <= 0; state <= ST_LO.
REQ-022 Reset asserted mid-check (CHK_HI or CHK_LO) SHALL abort the check without pulsing A_rise/A_fall and without incrementing glitch_cnt.
REQ-023 After rst_n returns to 1, a key_raw held at 1 SHALL be treated as a new rising transition (A rises after DEB_CYCLES+2 edges).
REQ-024 No output SHALL be X after the first reset edge.

Verification (DEB_CYCLES=16, sclk period 20 ns)
REQ-025 rst_n=0 for 100 ns, key_raw=0 -> A=0, A_rise=0, A_fall=0, glitch_cnt=0 throughout.
REQ-026 Clean step key_raw 0->1 held 300 cycles -> A=1 exactly 18 edges after first sampling edge, A_rise high for exactly 1 cycle, glitch_cnt=0.
REQ-027 key_raw pulses 1 for 5 cycles, 0 for 5 cycles, repeated 4 times, then 0 -> A stays 0, glitch_cnt=4, no pulses.
REQ-028 From A=1, key_raw 0 for exactly 15 cycles then back to 1 -> A stays 1, glitch_cnt +1; key_raw 0 held 16+ cycles -> A falls, A_fall single pulse.
REQ-029 300 alternating bounce bursts -> glitch_cnt saturates at 255, no wrap.
REQ-030 key_raw 0->1, rst_n pulsed low for 1 cycle at cnt=10 -> no A_rise, glitch_cnt=0; A rises 18 edges after rst_n release.
